// File: rtl/mips_harvard_mem_bridge_pkg.sv
// mips_bus_pkg: shared types and constants for the Harvard-core memory bridge.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mips_bus_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned BE_W       = DATA_W / 8;

    // Every bus access is a full aligned word.
    localparam logic [BE_W-1:0] BYTEEN_WORD = 4'b1111;

    // INSTR fetch -> optional DATA access -> RELEASE (step strobe); HALT is terminal.
    typedef enum logic [1:0] {
        INSTR   = 2'd0,
        DATA    = 2'd1,
        RELEASE = 2'd2,
        HALT    = 2'd3
    } bridge_state_t;

endpackage

// File: rtl/mips_harvard_mem_bridge_if.sv
// mips_harvard_mem_bridge_if: core-side split I/D ports plus the merged Avalon-style bus.
// Latency: n/a (wiring only).
// Backpressure: mem_waitrequest stalls the bus; the core is held by withholding clk_enable.
// Ports: master = bridge (drives bus + core results), slave = core/memory environment.
interface mips_harvard_mem_bridge_if #(
    parameter int unsigned ADDR_W = mips_bus_pkg::ADDR_W_DEF
) ();

    // core side
    logic                              clk_enable;
    logic [ADDR_W-1:0]                 instr_address;
    logic [mips_bus_pkg::DATA_W-1:0]   instr_readdata;
    logic [ADDR_W-1:0]                 data_address;
    logic                              data_read;
    logic                              data_write;
    logic [mips_bus_pkg::DATA_W-1:0]   data_writedata;
    logic [mips_bus_pkg::DATA_W-1:0]   data_readdata;
    logic                              fault;

    // memory side
    logic [ADDR_W-1:0]                 mem_address;
    logic                              mem_read;
    logic                              mem_write;
    logic [mips_bus_pkg::BE_W-1:0]     mem_byteenable;
    logic [mips_bus_pkg::DATA_W-1:0]   mem_writedata;
    logic [mips_bus_pkg::DATA_W-1:0]   mem_readdata;
    logic                              mem_waitrequest;

    modport master (
        input  instr_address, data_address, data_read, data_write, data_writedata,
        input  mem_readdata, mem_waitrequest,
        output clk_enable, instr_readdata, data_readdata, fault,
        output mem_address, mem_read, mem_write, mem_byteenable, mem_writedata
    );

    modport slave (
        output instr_address, data_address, data_read, data_write, data_writedata,
        output mem_readdata, mem_waitrequest,
        input  clk_enable, instr_readdata, data_readdata, fault,
        input  mem_address, mem_read, mem_write, mem_byteenable, mem_writedata
    );

endinterface

// File: rtl/mips_harvard_mem_bridge_watchdog.sv
// mips_bus_watchdog: counts consecutive stalled cycles of one transfer, flags timeout.
// Latency: expired_o is combinational from the registered count and the current stall.
// Backpressure: none; clear_i resets the count, TIMEOUT_CYCLES = 0 disables expiry.
// Ports: clk, rst (sync, active-high), stall_i, clear_i, expired_o.
module mips_bus_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic stall_i,
    input  logic clear_i,
    output logic expired_o
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_SAT = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES) : '1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (stall_i && (cnt_q != CNT_SAT)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Expiry needs the stall to persist once the count has reached the limit, so a
    // completion arriving in that same cycle still wins.
    assign expired_o = (TIMEOUT_CYCLES != 0) && stall_i && (cnt_q == CNT_SAT);

endmodule

// File: rtl/mips_harvard_mem_bridge.sv
// mips_harvard_mem_bridge: merges split I/D core ports onto one Avalon-style bus and steps the core.
// Latency: step = (instr waits + 1) + (data waits + 1 if data access) + 1 cycles.
// Backpressure: mem_waitrequest holds the request stable; core waits for the one-cycle clk_enable.
// Ports: clk, rst (sync, active-high), bus (master modport: core + memory signals).
module mips_harvard_mem_bridge
    import mips_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned ADDR_W         = ADDR_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    mips_harvard_mem_bridge_if.master bus
);

    bridge_state_t      state_q, state_d;
    logic [DATA_W-1:0]  instr_rd_q, instr_rd_d;
    logic [DATA_W-1:0]  data_rd_q, data_rd_d;

    logic               req_rd, req_wr, req_bad;
    logic [ADDR_W-1:0]  req_addr;
    logic [DATA_W-1:0]  req_wdata;
    logic               req_act, stall, done, expired, wd_clear;
    logic               bus_rd, bus_wr;

    // Request decode: a faulting access is never presented to the bus.
    always_comb begin
        req_rd    = 1'b0;
        req_wr    = 1'b0;
        req_bad   = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        case (state_q)
            INSTR: begin
                req_bad  = |bus.instr_address[1:0];
                req_rd   = ~req_bad;
                req_addr = {bus.instr_address[ADDR_W-1:2], 2'b00};
            end
            DATA: begin
                req_bad   = (|bus.data_address[1:0]) | (bus.data_read & bus.data_write);
                req_rd    = bus.data_read & ~req_bad;
                req_wr    = bus.data_write & ~req_bad;
                req_addr  = {bus.data_address[ADDR_W-1:2], 2'b00};
                req_wdata = bus.data_writedata;
            end
            default: ;
        endcase
    end

    assign req_act = req_rd | req_wr;
    assign stall   = req_act & bus.mem_waitrequest;
    assign done    = req_act & ~bus.mem_waitrequest;

    mips_bus_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .stall_i   (stall),
        .clear_i   (wd_clear),
        .expired_o (expired)
    );

    // Count restarts whenever the current request is not stalled or the state moves on.
    assign wd_clear = ~stall | (state_d != state_q);

    always_comb begin
        state_d    = state_q;
        instr_rd_d = instr_rd_q;
        data_rd_d  = data_rd_q;
        case (state_q)
            INSTR: begin
                if (req_bad || expired) begin
                    state_d = HALT;
                end else if (done) begin
                    instr_rd_d = bus.mem_readdata;
                    state_d    = (bus.data_read | bus.data_write) ? DATA : RELEASE;
                end
            end
            DATA: begin
                if (req_bad || expired) begin
                    state_d = HALT;
                end else if (done) begin
                    if (bus.data_read) begin
                        data_rd_d = bus.mem_readdata;
                    end
                    state_d = RELEASE;
                end else if (!req_act) begin
                    // Access request withdrawn: nothing to do, finish the step.
                    state_d = RELEASE;
                end
            end
            RELEASE: state_d = INSTR;
            default: state_d = HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= INSTR;
            instr_rd_q <= '0;
            data_rd_q  <= '0;
        end else begin
            state_q    <= state_d;
            instr_rd_q <= instr_rd_d;
            data_rd_q  <= data_rd_d;
        end
    end

    // Bus strobes drop in the very cycle rst rises, abandoning any transfer in flight.
    assign bus_rd = req_rd & ~rst;
    assign bus_wr = req_wr & ~rst;

    assign bus.mem_read       = bus_rd;
    assign bus.mem_write      = bus_wr;
    assign bus.mem_address    = req_addr;
    assign bus.mem_writedata  = req_wdata;
    assign bus.mem_byteenable = (bus_rd | bus_wr) ? BYTEEN_WORD : '0;

    assign bus.clk_enable     = (state_q == RELEASE) & ~rst;
    assign bus.fault          = (state_q == HALT) & ~rst;
    assign bus.instr_readdata = instr_rd_q;
    assign bus.data_readdata  = data_rd_q;

endmodule

// File: tb/tb_mips_harvard_mem_bridge.sv
// tb_mips_harvard_mem_bridge: directed steps against a trace model of the bridge.
// Latency: each step's expected per-cycle bus trace is built from the step-latency rule.
// Backpressure: the bench plays memory, holding waitrequest for a per-transfer wait count.
module tb_mips_harvard_mem_bridge;
    import mips_bus_pkg::*;

    localparam int unsigned TO = 8;
    localparam int K_INSTR = 0;
    localparam int K_DATA  = 1;
    localparam int K_REL   = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mips_harvard_mem_bridge_if #(.ADDR_W(32)) bus_if ();

    mips_harvard_mem_bridge #(
        .TIMEOUT_CYCLES(TO),
        .ADDR_W        (32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    // One expected cycle of the bus/core outputs.
    typedef struct {
        int          kind;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        last;
    } cyc_t;

    cyc_t        exp_q[$];
    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          rel_cyc = 0;
    int          last_ce = 0;
    int          prev_ce = 0;
    int          act_rd_cnt = 0;
    int          act_wr_cnt = 0;
    logic [31:0] m_instr = '0;
    logic [31:0] m_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_xfer(input int kind, input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] rdata, input int waits);
        for (int i = 0; i <= waits; i++) begin
            cyc_t e;
            e.kind = kind; e.rd = rd; e.wr = wr; e.addr = addr;
            e.wdata = wdata; e.rdata = rdata; e.last = (i == waits);
            exp_q.push_back(e);
        end
    endtask

    // Plays memory for each expected cycle and checks the DUT against it.
    task automatic run_trace();
        act_rd_cnt = 0;
        act_wr_cnt = 0;
        foreach (exp_q[i]) begin
            cyc_t e;
            e = exp_q[i];
            bus_if.mem_waitrequest = (e.rd | e.wr) ? ~e.last : 1'b0;
            bus_if.mem_readdata    = (e.rd && e.last) ? e.rdata : 32'hBAD0_BAD0;
            #1;
            chk("mem_read", bus_if.mem_read, e.rd);
            chk("mem_write", bus_if.mem_write, e.wr);
            chk("mem_byteenable", bus_if.mem_byteenable, (e.rd | e.wr) ? 32'hF : 32'h0);
            if (e.rd | e.wr) chk("mem_address", bus_if.mem_address, e.addr);
            if (e.wr) chk("mem_writedata", bus_if.mem_writedata, e.wdata);
            chk("clk_enable", bus_if.clk_enable, e.kind == K_REL);
            chk("fault", bus_if.fault, 1'b0);
            if (e.kind == K_REL) begin
                chk("instr_readdata", bus_if.instr_readdata, m_instr);
                chk("data_readdata", bus_if.data_readdata, m_data);
                prev_ce = last_ce;
                last_ce = cyc;
            end
            if (e.kind == K_DATA) begin
                act_rd_cnt += int'(bus_if.mem_read);
                act_wr_cnt += int'(bus_if.mem_write);
            end
            @(posedge clk);
            if (e.last && e.rd) begin
                if (e.kind == K_INSTR) m_instr = e.rdata;
                else m_data = e.rdata;
            end
            @(negedge clk);
        end
    endtask

    task automatic run_step(input logic [31:0] ia, input logic [31:0] iword, input int iw,
                            input logic dr, input logic dw, input logic [31:0] da,
                            input logic [31:0] wd, input logic [31:0] rword, input int dwt);
        bus_if.instr_address  = ia;
        bus_if.data_read      = dr;
        bus_if.data_write     = dw;
        bus_if.data_address   = da;
        bus_if.data_writedata = wd;
        exp_q.delete();
        push_xfer(K_INSTR, 1'b1, 1'b0, ia, 32'h0, iword, iw);
        if (dr | dw) push_xfer(K_DATA, dr, dw, da, wd, rword, dwt);
        push_xfer(K_REL, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 0);
        run_trace();
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        bus_if.instr_address   = '0;
        bus_if.data_address    = '0;
        bus_if.data_read       = 1'b0;
        bus_if.data_write      = 1'b0;
        bus_if.data_writedata  = '0;
        bus_if.mem_waitrequest = 1'b0;
        bus_if.mem_readdata    = '0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mem_read", bus_if.mem_read, 1'b0);
        chk("rst_mem_write", bus_if.mem_write, 1'b0);
        chk("rst_byteenable", bus_if.mem_byteenable, 32'h0);
        chk("rst_clk_enable", bus_if.clk_enable, 1'b0);
        chk("rst_fault", bus_if.fault, 1'b0);
        chk("rst_instr_readdata", bus_if.instr_readdata, 32'h0);
        chk("rst_data_readdata", bus_if.data_readdata, 32'h0);
        rst = 1'b0;
        m_instr = '0;
        m_data  = '0;
        rel_cyc = cyc;
        #1;
        // Released into INSTR: a fetch of address 0 is presented at once.
        chk("post_rst_fetch", bus_if.mem_read, 1'b1);
        chk("post_rst_fault", bus_if.fault, 1'b0);
    endtask

    task automatic fault_case(input string name, input logic [31:0] ia, input logic dr,
                              input logic dw, input logic [31:0] da);
        reset_dut();
        bus_if.instr_address   = ia;
        bus_if.data_read       = dr;
        bus_if.data_write      = dw;
        bus_if.data_address    = da;
        bus_if.data_writedata  = 32'h5555_AAAA;
        bus_if.mem_waitrequest = 1'b0;
        bus_if.mem_readdata    = 32'h0000_0013;
        #1;
        if (ia[1:0] == 2'b00) begin
            chk({name, "_fetch"}, bus_if.mem_read, 1'b1);
            @(posedge clk);
            @(negedge clk);
            #1;
        end
        chk({name, "_no_read"}, bus_if.mem_read, 1'b0);
        chk({name, "_no_write"}, bus_if.mem_write, 1'b0);
        chk({name, "_fault_early"}, bus_if.fault, 1'b0);
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            chk({name, "_halt_fault"}, bus_if.fault, 1'b1);
            chk({name, "_halt_read"}, bus_if.mem_read, 1'b0);
            chk({name, "_halt_write"}, bus_if.mem_write, 1'b0);
            chk({name, "_halt_ce"}, bus_if.clk_enable, 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        reset_dut();

        // Zero-wait fetch-only steps: pulse every 2 cycles.
        run_step(32'h0, 32'h2402_0005, 0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 0);
        chk("first_step_edge", 32'(last_ce - rel_cyc + 1), 32'd2);
        chk("fetch_value", bus_if.instr_readdata, 32'h2402_0005);
        run_step(32'h4, 32'h2403_0007, 0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 0);
        chk("pulse_period", 32'(last_ce - prev_ce), 32'd2);

        // Load with 3 data wait cycles, fetch with 1.
        run_step(32'h8, 32'h8C04_0100, 1, 1'b1, 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF, 3);
        chk("load_value", bus_if.data_readdata, 32'hDEAD_BEEF);
        chk("load_rd_cycles", 32'(act_rd_cnt), 32'd4);

        // Store: one write cycle, load data untouched.
        run_step(32'hC, 32'hAC05_0200, 0, 1'b0, 1'b1, 32'h200, 32'h1234_5678, 32'h0, 0);
        chk("store_wr_cycles", 32'(act_wr_cnt), 32'd1);
        chk("store_keeps_load", bus_if.data_readdata, 32'hDEAD_BEEF);

        // Stalled store and a slow fetch.
        run_step(32'h10, 32'h0000_0000, 2, 1'b0, 1'b1, 32'h204, 32'hA5A5_5A5A, 32'h0, 2);
        run_step(32'h14, 32'h1000_FFFF, 0, 1'b1, 1'b0, 32'h300, 32'h0, 32'h0BAD_CAFE, 0);

        // Reset during a stalled DATA write.
        bus_if.instr_address   = 32'h10;
        bus_if.data_write      = 1'b1;
        bus_if.data_read       = 1'b0;
        bus_if.data_address    = 32'h200;
        bus_if.data_writedata  = 32'hCAFE_F00D;
        bus_if.mem_waitrequest = 1'b0;
        bus_if.mem_readdata    = 32'h1111_1111;
        @(posedge clk);
        @(negedge clk);
        bus_if.mem_waitrequest = 1'b1;
        #1;
        chk("mid_write_active", bus_if.mem_write, 1'b1);
        rst = 1'b1;
        #1;
        chk("rst_drops_write", bus_if.mem_write, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus_if.mem_waitrequest = 1'b0;
        #1;
        chk("rst_back_instr", bus_if.mem_read, 1'b1);
        chk("rst_back_addr", bus_if.mem_address, 32'h10);
        chk("rst_back_write", bus_if.mem_write, 1'b0);
        chk("rst_back_instr_rd", bus_if.instr_readdata, 32'h0);
        chk("rst_back_data_rd", bus_if.data_readdata, 32'h0);
        chk("rst_back_fault", bus_if.fault, 1'b0);
        m_instr = '0;
        m_data  = '0;
        run_step(32'h10, 32'h2406_0001, 0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 0);

        // Faults: misaligned load, read+write together, misaligned fetch.
        fault_case("misaligned_data", 32'h8, 1'b1, 1'b0, 32'h102);
        fault_case("rd_and_wr", 32'h8, 1'b1, 1'b1, 32'h100);
        fault_case("misaligned_instr", 32'h6, 1'b0, 1'b0, 32'h0);

        // Watchdog: count reaches TO after TO stalls; the next stalled cycle faults.
        reset_dut();
        bus_if.instr_address   = 32'h40;
        bus_if.mem_waitrequest = 1'b1;
        for (int k = 0; k <= int'(TO); k++) begin
            #1;
            chk("to_stall_read", bus_if.mem_read, 1'b1);
            chk("to_stall_fault", bus_if.fault, 1'b0);
            @(posedge clk);
            @(negedge clk);
        end
        repeat (4) begin
            #1;
            chk("to_fault", bus_if.fault, 1'b1);
            chk("to_read_dropped", bus_if.mem_read, 1'b0);
            chk("to_no_ce", bus_if.clk_enable, 1'b0);
            @(posedge clk);
            @(negedge clk);
        end

        // Only rst leaves HALT.
        reset_dut();
        run_step(32'h0, 32'h2402_0005, 0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
